// File: rtl/uart_receive.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM, one-cycle valid/error strobes.
// Optional even-parity bit after data bit 7 when UART_RX_PARITY_EN is defined (adds parity_error_out).
module uart_receive #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 460800
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rx_wire_in,
    output logic [7:0] data_byte_out,
    output logic       valid_out,
    output logic       framing_error_out,
`ifdef UART_RX_PARITY_EN
    output logic       parity_error_out,
`endif
    output logic       busy_out
);

    localparam int CLKS_PER_BIT = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

`ifdef UART_RX_PARITY_EN
    // Even parity: XOR over data and parity bit must be zero.
    function automatic logic parity_mismatch(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             sync1_q, sync2_q;
    logic             rx_s;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
    logic             perr_q, perr_d;
`endif

    assign rx_s = sync2_q;

    // Next-state and output-strobe decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = CNT_ZERO;
                    idx_d = 3'd0;
                    // A line that is high again at mid-start was only a glitch.
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    shreg_d = {rx_s, shreg_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = CNT_ZERO;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = CNT_ZERO;
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (rx_s) begin
                        state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        if (parity_mismatch(shreg_q, par_q)) begin
                            perr_d = 1'b1;
                        end else begin
                            data_d  = shreg_q;
                            valid_d = 1'b1;
                        end
`else
                        data_d  = shreg_q;
                        valid_d = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_IDLE: begin
                cnt_d = CNT_ZERO;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = 3'd0;
            end
        endcase
    end

    // State, datapath and synchronizer registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            sync1_q <= rx_wire_in;
            sync2_q <= sync1_q;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign data_byte_out     = data_q;
    assign valid_out         = valid_q;
    assign framing_error_out = ferr_q;
    assign busy_out          = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error_out  = perr_q;
`endif

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
- UART receiver; the receive-side counterpart of the design's uart_transmit.
- Recovers 8N1 bytes from an asynchronous serial line and emits each byte with a one-cycle valid strobe.
- Uses: host→FPGA control and config (e.g. runtime yin/tuning parameters), and loopback verification of the transmit path.

Parameters:
- INPUT_CLOCK_FREQ, 100_000_000, clk_in frequency in Hz.
- BAUD_RATE, 460800, line bit rate.
- Derived constants, not overridable:
  - CLKS_PER_BIT = INPUT_CLOCK_FREQ / BAUD_RATE, integer floor; 217 at defaults.
  - HALF_BIT = CLKS_PER_BIT / 2; 108 at defaults.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- rx_wire_in  input  1  asynchronous serial line; idles high.
- data_byte_out  output  8  last correctly framed byte; holds its value between frames.
- valid_out  output  1  one-cycle pulse when data_byte_out updates.
- framing_error_out  output  1  one-cycle pulse when the stop bit is sampled low.
- busy_out  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_in=0, async):
  - State = IDLE; all counters = 0; shift register = 0.
  - Both synchronizer flops = 1.
  - data_byte_out = 0x00; valid_out = 0; framing_error_out = 0; busy_out = 0.
  - Reset asserted mid-frame aborts the frame: no valid or error pulse for it.
- Input path: two-flop synchronizer on rx_wire_in. All decisions use the synchronized bit rx_s.
- State machine (counter = cycle counter, bit_idx = 0..7):
  - IDLE: rx_s=0 → START, counter=0.
  - START: counter increments. At counter==HALF_BIT-1, sample rx_s:
    - 1 → glitch; return to IDLE, no output.
    - 0 → DATA, counter=0, bit_idx=0.
  - DATA: at counter==CLKS_PER_BIT-1, sample rx_s.
    - Shift it in LSB-first: shreg <= {rx_s, shreg[7:1]}.
    - Reset counter and increment bit_idx.
    - After bit_idx 7 → STOP.
  - STOP: at counter==CLKS_PER_BIT-1, sample rx_s:
    - 1 → data_byte_out <= shreg; valid_out=1 for the next cycle; → IDLE.
    - 0 → framing_error_out=1 for the next cycle; data_byte_out unchanged; → WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then → IDLE. Prevents a break condition from retriggering reception.
- Sample points fall at bit centres, spaced CLKS_PER_BIT apart.
- Latency: pulse asserts HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the IDLE→START transition, plus 2 cycles of synchronizer delay from the pin.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with zero idle time.
- valid_out and framing_error_out are mutually exclusive and never asserted two cycles in a row.
- Tolerance: correct reception with sender bit period within ±3% of nominal.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An even-parity bit follows data bit 7. STOP is entered via a PARITY state that samples the bit at counter==CLKS_PER_BIT-1.
  - Adds output parity_error_out (1 bit, reset 0).
  - If the XOR of 8 data bits and the parity bit is 1, parity_error_out pulses concurrently with the stop-bit decision; valid_out is suppressed and data_byte_out is unchanged.
  - Framing error takes precedence: only framing_error_out pulses.
- Undefined: 8N1 only; no PARITY state; no parity_error_out port.

Test Plan:
- Send 0xA5 (8N1) at 460800 baud, 100 MHz → exactly one valid_out pulse with data_byte_out=0xA5; framing_error_out stays 0; busy_out falls the same cycle the pulse rises.
- Back-to-back 0x00, 0xFF, 0x3C with no idle gap → three valid pulses, data 0x00/0xFF/0x3C in order.
- 50-cycle low glitch on an idle line → busy_out high for about 110 cycles then back to IDLE; no valid or error pulse.
- Frame 0x5A with stop bit driven low, line held low 5 bit-times → one framing_error_out pulse; data_byte_out keeps its previous value; no new START until the line goes high; a following 0x11 is received correctly.
- rst_in low for 3 cycles during data bit 4 of 0x77 → outputs return to reset values; no pulse; next 0x77 is received correctly.
- Sender period 3% slow and 3% fast, byte 0x81 → received as 0x81 both times. With UART_RX_PARITY_EN: 0x81 with wrong parity → parity_error_out pulse and no valid_out.
